instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end fetch stage of the core. Holds the 64-bit program counter, issues 32-bit instruction reads to instruction memory over a req/ready handshake, and presents each fetched word with its PC and a pre-decoded immediate-type code in a one-entry output buffer. The downstream immediate decoder consumes `INSTRUCTION` and `SELECTION` directly. Branch/jump redirects flush the buffer and restart fetch at the new PC.

## Interface
- `RESET_PC`, default `64'h0`: PC loaded on reset; must be 4-byte aligned.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `IMEM_REQ` output 1: read request to instruction memory.
- `IMEM_ADDR` output 64: byte address of the request; always equals the internal PC.
- `IMEM_READY` input 1: read completes in any cycle where `IMEM_REQ` and `IMEM_READY` are both high.
- `IMEM_RDATA` input 32: instruction word; valid in the completing cycle.
- `REDIRECT` input 1: one-cycle pulse requesting a fetch restart.
- `REDIRECT_PC` input 64: target for `REDIRECT`.
- `STALL` input 1: downstream cannot accept the buffered instruction this cycle.
- `VALID` output 1: output buffer holds an instruction.
- `INSTRUCTION` output 32: buffered instruction word.
- `PC_OUT` output 64: address of `INSTRUCTION`.
- `SELECTION` output 3: immediate type of `INSTRUCTION`, in the encoding the immediate decoder expects.
- `FAULT` output 1: sticky misaligned-redirect flag.

## Operation
- FSM states:
  - BOOT: entered on reset.
  - FETCH
  - FLUSH
  - FAULT
- Transitions:
  - BOOT→FETCH unconditionally after one cycle.
  - FETCH→FLUSH on an aligned `REDIRECT`.
  - FETCH or FLUSH→FAULT on a `REDIRECT` with `REDIRECT_PC[1:0]` ≠ 0.
  - FLUSH→FETCH after one cycle.
  - FAULT is left only by reset.
- `IMEM_REQ` is asserted only when all three hold: state is FETCH, no `REDIRECT` this cycle, and the buffer is free or draining (`!VALID || !STALL`).
- Completion in FETCH (`IMEM_REQ && IMEM_READY`):
  - The buffer loads `IMEM_RDATA`, the current PC and the decoded `SELECTION`.
  - `VALID` goes to 1.
  - PC advances by 4; the addition is modulo 2^64, so it wraps silently.
- Consumption: a cycle with `VALID && !STALL`. If no completion occurs in the same cycle, `VALID` goes to 0.
- Consumption and completion in the same cycle: the buffer reloads and `VALID` stays 1.
- `REDIRECT` has highest priority:
  - The buffer is flushed and `VALID` goes to 0 next cycle, even if the instruction is consumed in the same cycle.
  - Any `IMEM_READY` in that cycle is ignored; `IMEM_REQ` is already low.
  - PC loads `REDIRECT_PC`.
  - A `REDIRECT` in BOOT is ignored.
- Misaligned `REDIRECT`: PC is not updated, `FAULT` goes to 1 and stays 1. The block stays idle: no requests, `VALID` = 0, further redirects ignored.
- `SELECTION` decode from `IMEM_RDATA[6:0]`:
  - 1 (I): 0010011, 0000011, 1100111, 0011011, 1110011.
  - 2 (U): 0110111, 0010111.
  - 3 (S): 0100011.
  - 4 (B): 1100011.
  - 5 (UJ): 1101111.
  - 0: all other opcodes, including R-type.
- While `VALID` = 1 and `STALL` = 1, `INSTRUCTION`, `PC_OUT` and `SELECTION` are held stable.

## Timing
- Reset values (asynchronous):
  - State BOOT; internal PC = `RESET_PC`.
  - `IMEM_REQ` = 0, `IMEM_ADDR` = `RESET_PC`.
  - `VALID` = 0, `INSTRUCTION` = 0, `PC_OUT` = 0, `SELECTION` = 0, `FAULT` = 0.
- First request: `IMEM_REQ` = 1 in the second cycle after `RST_N` deasserts.
- Latency: completion at edge N gives `VALID` = 1 with that word from cycle N+1.
- Throughput: with `IMEM_READY` held high and `STALL` low, one instruction per cycle.
- Redirect penalty:
  - `REDIRECT` in cycle R: `IMEM_REQ` = 0 in cycles R and R+1 (FLUSH).
  - Request to `REDIRECT_PC` in cycle R+2.
  - Earliest `VALID` for the target instruction is R+3.
- `RST_N` asserted mid-operation (including FAULT or a pending request): all state returns to reset values immediately. No completion is recorded.
- `IMEM_READY` while `IMEM_REQ` = 0 has no effect.

## Test plan
- Reset release, `RESET_PC`=0x1000, `IMEM_READY`=1, `STALL`=0, memory returns 0x00500093 then 0x000012b7 → `IMEM_ADDR` 0x1000, 0x1004, …
  - First `VALID` 3 cycles after reset release.
  - Outputs `PC_OUT`=0x1000, `SELECTION`=1, then `PC_OUT`=0x1004, `SELECTION`=2.
- `STALL` high for 3 cycles while `VALID`=1 → outputs frozen and `IMEM_REQ`=0 during the stall. Fetch resumes the cycle `STALL` drops, with no lost or duplicated instruction.
- `REDIRECT` to 0x2000 in the same cycle as `IMEM_READY` → that word is discarded and `VALID`=0 next cycle. `IMEM_REQ` is low for 2 cycles, then `IMEM_ADDR`=0x2000.
- `REDIRECT_PC`=0x2002 → `FAULT`=1 and `IMEM_REQ`=0 forever. A later `REDIRECT` to 0x3000 is ignored; `RST_N` pulse clears `FAULT`.
- Opcode sweep 0100011, 1100011, 1101111, 0110011 → `SELECTION` 3, 4, 5, 0.
- `RST_N` pulsed low while `IMEM_REQ`=1 and `IMEM_READY`=0 → all outputs return to reset values immediately. Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front-end fetch stage. Owns the 64-bit program counter, issues 32-bit reads
// to instruction memory over a REQ/READY handshake and keeps the most recently
// fetched word, its PC and its pre-decoded immediate type in a one-entry
// output buffer. A REDIRECT flushes the buffer and restarts fetch at the new
// PC. A misaligned redirect target parks the block in a sticky fault state
// that only reset clears.
//
// Ports
//   CLK          in   1   clock, rising edge
//   RST_N        in   1   asynchronous active-low reset
//   IMEM_REQ     out  1   read request to instruction memory
//   IMEM_ADDR    out  64  byte address of the request (current PC)
//   IMEM_READY   in   1   read completes when REQ and READY are both high
//   IMEM_RDATA   in   32  instruction word, valid in the completing cycle
//   REDIRECT     in   1   one-cycle fetch restart request
//   REDIRECT_PC  in   64  restart target
//   STALL        in   1   downstream cannot take the buffered instruction
//   VALID        out  1   output buffer holds an instruction
//   INSTRUCTION  out  32  buffered instruction word
//   PC_OUT       out  64  address of INSTRUCTION
//   SELECTION    out  3   immediate type of INSTRUCTION (0 none, 1 I, 2 U,
//                         3 S, 4 B, 5 UJ)
//   FAULT        out  1   sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [63:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [63:0] REDIRECT_PC,
  input  logic        STALL,
  output logic        VALID,
  output logic [31:0] INSTRUCTION,
  output logic [63:0] PC_OUT,
  output logic [2:0]  SELECTION,
  output logic        FAULT
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_FLUSH,
    S_FAULT
  } state_t;

  state_t      state_p0, state_nxt;
  logic [63:0] pc_p0;
  logic        fault_p0;

  logic        vld_p1;
  logic [31:0] ins_p1;
  logic [63:0] pc_p1;
  logic [2:0]  sel_p1;

  logic        redirect_take;
  logic        redirect_bad;
  logic        req;
  logic        complete;
  logic        consume;

  // Immediate-type pre-decode from the major opcode field.
  function automatic logic [2:0] decode_sel(input logic [6:0] opcode);
    logic [2:0] sel;
    sel = 3'd0;
    unique case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b0011011, 7'b1110011:             sel = 3'd1;
      7'b0110111, 7'b0010111:             sel = 3'd2;
      7'b0100011:                         sel = 3'd3;
      7'b1100011:                         sel = 3'd4;
      7'b1101111:                         sel = 3'd5;
      default:                            sel = 3'd0;
    endcase
    return sel;
  endfunction

  // Redirects are honoured only once fetch is running; BOOT and FAULT drop them.
  always_comb begin
    redirect_take = REDIRECT && ((state_p0 == S_FETCH) || (state_p0 == S_FLUSH));
    redirect_bad  = redirect_take && (REDIRECT_PC[1:0] != 2'b00);
    req           = (state_p0 == S_FETCH) && !REDIRECT && (!vld_p1 || !STALL);
    complete      = req && IMEM_READY;
    consume       = vld_p1 && !STALL;
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (redirect_bad)       state_nxt = S_FAULT;
        else if (redirect_take) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // A fresh aligned redirect here restarts the one-cycle flush.
        if (redirect_bad)       state_nxt = S_FAULT;
        else if (redirect_take) state_nxt = S_FLUSH;
        else                    state_nxt = S_FETCH;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_BOOT;
    endcase
  end

  // ---- stage p0: fetch control and program counter ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p0 <= S_BOOT;
      pc_p0    <= RESET_PC;
      fault_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (redirect_bad) begin
        fault_p0 <= 1'b1;
      end else if (redirect_take) begin
        pc_p0 <= REDIRECT_PC;
      end else if (complete) begin
        pc_p0 <= pc_p0 + 64'd4;
      end
    end
  end

  // ---- stage p1: one-entry output buffer ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
      ins_p1 <= '0;
      pc_p1  <= '0;
      sel_p1 <= '0;
    end else begin
      if (redirect_take) begin
        vld_p1 <= 1'b0;
      end else if (complete) begin
        vld_p1 <= 1'b1;
      end else if (consume) begin
        vld_p1 <= 1'b0;
      end
      if (complete) begin
        ins_p1 <= IMEM_RDATA;
        pc_p1  <= pc_p0;
        sel_p1 <= decode_sel(IMEM_RDATA[6:0]);
      end
    end
  end

  assign IMEM_REQ    = req;
  assign IMEM_ADDR   = pc_p0;
  assign VALID       = vld_p1;
  assign INSTRUCTION = ins_p1;
  assign PC_OUT      = pc_p1;
  assign SELECTION   = sel_p1;
  assign FAULT       = fault_p0;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. A memory model answers reads from
// a fixed address map; every completed handshake pushes the expected
// {pc, word, selection} onto a scoreboard queue and every consumption pops and
// compares it. Directed cycle-accurate checks cover reset, latency, stall,
// redirect penalty, fault and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        CLK;
  logic        RST_N;
  logic        IMEM_REQ;
  logic [63:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic [31:0] IMEM_RDATA;
  logic        REDIRECT;
  logic [63:0] REDIRECT_PC;
  logic        STALL;
  logic        VALID;
  logic [31:0] INSTRUCTION;
  logic [63:0] PC_OUT;
  logic [2:0]  SELECTION;
  logic        FAULT;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [2:0]  sel;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_pc;
  logic        model_fault;
  int          n_checks;
  int          n_errors;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_READY  (IMEM_READY),
    .IMEM_RDATA  (IMEM_RDATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .STALL       (STALL),
    .VALID       (VALID),
    .INSTRUCTION (INSTRUCTION),
    .PC_OUT      (PC_OUT),
    .SELECTION   (SELECTION),
    .FAULT       (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] op_of(input logic [2:0] idx);
    logic [6:0] op;
    case (idx)
      3'd0:    op = 7'b0010011;
      3'd1:    op = 7'b0000011;
      3'd2:    op = 7'b1100111;
      3'd3:    op = 7'b0011011;
      3'd4:    op = 7'b1110011;
      3'd5:    op = 7'b0110111;
      3'd6:    op = 7'b0010111;
      default: op = 7'b0110011;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    case (a)
      64'h1000: w = 32'h00500093;
      64'h1004: w = 32'h000012b7;
      64'h2000: w = 32'h00112023;
      64'h2004: w = 32'h00000463;
      64'h2008: w = 32'h0080006f;
      64'h200c: w = 32'h002081b3;
      default:  w = {a[26:2], op_of(a[4:2])};
    endcase
    return w;
  endfunction

  function automatic logic [2:0] ref_sel(input logic [31:0] w);
    logic [2:0] s;
    case (w[6:0])
      7'b0010011: s = 3'd1;
      7'b0000011: s = 3'd1;
      7'b1100111: s = 3'd1;
      7'b0011011: s = 3'd1;
      7'b1110011: s = 3'd1;
      7'b0110111: s = 3'd2;
      7'b0010111: s = 3'd2;
      7'b0100011: s = 3'd3;
      7'b1100011: s = 3'd4;
      7'b1101111: s = 3'd5;
      default:    s = 3'd0;
    endcase
    return s;
  endfunction

  assign IMEM_RDATA = mem_word(IMEM_ADDR);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      sb.delete();
      exp_pc      = RST_PC;
      model_fault = 1'b0;
    end else if (REDIRECT) begin
      sb.delete();
      if (!model_fault) begin
        if (REDIRECT_PC[1:0] != 2'b00) model_fault = 1'b1;
        else                           exp_pc = REDIRECT_PC;
      end
    end else begin
      if (VALID && !STALL) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_pc", PC_OUT, e.pc);
          check("sb_ins", {32'd0, INSTRUCTION}, {32'd0, e.ins});
          check("sb_sel", {61'd0, SELECTION}, {61'd0, e.sel});
        end
      end
      if (IMEM_REQ && IMEM_READY) begin
        check("sb_addr", IMEM_ADDR, exp_pc);
        e.pc  = exp_pc;
        e.ins = mem_word(exp_pc);
        e.sel = ref_sel(e.ins);
        sb.push_back(e);
        exp_pc = exp_pc + 64'd4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap;
    n_checks    = 0;
    n_errors    = 0;
    exp_pc      = RST_PC;
    model_fault = 1'b0;
    RST_N       = 1'b0;
    IMEM_READY  = 1'b0;
    STALL       = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;

    // Reset values
    tick; tick;
    check("rst_req", {63'd0, IMEM_REQ}, 64'd0);
    check("rst_addr", IMEM_ADDR, RST_PC);
    check("rst_valid", {63'd0, VALID}, 64'd0);
    check("rst_ins", {32'd0, INSTRUCTION}, 64'd0);
    check("rst_pcout", PC_OUT, 64'd0);
    check("rst_sel", {61'd0, SELECTION}, 64'd0);
    check("rst_fault", {63'd0, FAULT}, 64'd0);

    // Release and first fetches
    IMEM_READY = 1'b1;
    RST_N      = 1'b1;
    #1;
    check("boot_req", {63'd0, IMEM_REQ}, 64'd0);
    tick;
    check("first_req", {63'd0, IMEM_REQ}, 64'd1);
    check("first_addr", IMEM_ADDR, 64'h1000);
    check("first_novalid", {63'd0, VALID}, 64'd0);
    tick;
    check("first_valid", {63'd0, VALID}, 64'd1);
    check("first_pcout", PC_OUT, 64'h1000);
    check("first_ins", {32'd0, INSTRUCTION}, 64'h00500093);
    check("first_sel", {61'd0, SELECTION}, 64'd1);
    check("second_addr", IMEM_ADDR, 64'h1004);

    // Stall for three cycles while holding 0x1004
    tick;
    STALL = 1'b1;
    #1;
    check("second_pcout", PC_OUT, 64'h1004);
    check("second_sel", {61'd0, SELECTION}, 64'd2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick;
      check("stall_req", {63'd0, IMEM_REQ}, 64'd0);
      check("stall_valid", {63'd0, VALID}, 64'd1);
      check("stall_pcout", PC_OUT, 64'h1004);
      check("stall_ins", {32'd0, INSTRUCTION}, 64'h000012b7);
      check("stall_sel", {61'd0, SELECTION}, 64'd2);
    end
    tick;
    STALL = 1'b0;
    #1;
    check("resume_req", {63'd0, IMEM_REQ}, 64'd1);
    check("resume_addr", IMEM_ADDR, 64'h1008);
    tick;
    check("resume_pcout", PC_OUT, 64'h1008);

    // Redirect to 0x2000 in a cycle with READY high
    tick;
    REDIRECT    = 1'b1;
    REDIRECT_PC = 64'h2000;
    #1;
    check("redir_req0", {63'd0, IMEM_REQ}, 64'd0);
    tick;
    REDIRECT = 1'b0;
    #1;
    check("redir_valid", {63'd0, VALID}, 64'd0);
    check("redir_req1", {63'd0, IMEM_REQ}, 64'd0);
    tick;
    check("redir_req2", {63'd0, IMEM_REQ}, 64'd1);
    check("redir_addr", IMEM_ADDR, 64'h2000);
    tick;
    check("redir_tgt_valid", {63'd0, VALID}, 64'd1);
    check("redir_tgt_pc", PC_OUT, 64'h2000);
    check("sweep_s", {61'd0, SELECTION}, 64'd3);
    tick;
    check("sweep_b", {61'd0, SELECTION}, 64'd4);
    tick;
    check("sweep_uj", {61'd0, SELECTION}, 64'd5);
    tick;
    check("sweep_r", {61'd0, SELECTION}, 64'd0);
    check("sweep_r_pc", PC_OUT, 64'h200c);

    // Randomised READY/STALL with occasional aligned redirects
    for (int i = 0; i < 300; i++) begin
      tick;
      IMEM_READY = ($urandom_range(0, 3) != 0);
      STALL      = ($urandom_range(0, 3) == 0);
      REDIRECT   = ($urandom_range(0, 15) == 0);
      REDIRECT_PC = 64'h4000 + 64'($urandom_range(0, 63)) * 64'd4;
    end
    tick;
    REDIRECT   = 1'b0;
    STALL      = 1'b0;
    IMEM_READY = 1'b1;
    repeat (4) tick;

    // Misaligned redirect -> sticky fault
    REDIRECT    = 1'b1;
    REDIRECT_PC = 64'h2002;
    #1;
    snap = exp_pc;
    tick;
    REDIRECT = 1'b0;
    #1;
    check("fault_set", {63'd0, FAULT}, 64'd1);
    check("fault_valid", {63'd0, VALID}, 64'd0);
    check("fault_req", {63'd0, IMEM_REQ}, 64'd0);
    check("fault_addr", IMEM_ADDR, snap);
    tick;
    REDIRECT    = 1'b1;
    REDIRECT_PC = 64'h3000;
    tick;
    REDIRECT = 1'b0;
    repeat (2) begin
      tick;
      check("fault_hold", {63'd0, FAULT}, 64'd1);
      check("fault_req_hold", {63'd0, IMEM_REQ}, 64'd0);
      check("fault_addr_hold", IMEM_ADDR, snap);
      check("fault_valid_hold", {63'd0, VALID}, 64'd0);
    end
    tick;
    RST_N = 1'b0;
    #1;
    check("fault_clr", {63'd0, FAULT}, 64'd0);
    check("fault_rst_addr", IMEM_ADDR, RST_PC);
    tick;
    RST_N = 1'b1;
    tick;
    check("restart_req", {63'd0, IMEM_REQ}, 64'd1);
    check("restart_addr", IMEM_ADDR, RST_PC);
    repeat (4) tick;

    // Async reset while a request is pending
    IMEM_READY = 1'b0;
    #1;
    check("pend_req", {63'd0, IMEM_REQ}, 64'd1);
    check("pend_valid", {63'd0, VALID}, 64'd1);
    RST_N = 1'b0;
    #1;
    check("arst_req", {63'd0, IMEM_REQ}, 64'd0);
    check("arst_valid", {63'd0, VALID}, 64'd0);
    check("arst_ins", {32'd0, INSTRUCTION}, 64'd0);
    check("arst_pcout", PC_OUT, 64'd0);
    check("arst_sel", {61'd0, SELECTION}, 64'd0);
    check("arst_addr", IMEM_ADDR, RST_PC);
    tick;
    RST_N      = 1'b1;
    IMEM_READY = 1'b1;
    tick;
    check("arst_restart_addr", IMEM_ADDR, RST_PC);
    tick;
    check("arst_restart_pc", PC_OUT, RST_PC);
    repeat (3) tick;

    // Drain: stop fetching and let the buffer empty
    IMEM_READY = 1'b0;
    for (int i = 0; i < 20 && VALID; i++) tick;
    tick;
    check("drain_valid", {63'd0, VALID}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
